spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_clk_gen.sv | 54 +++++
 rtl/spi_master.sv | 130 +++++++++++++
 tb/tb_spi_master.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, frame width and bus mode.
package spi_pkg;

    localparam int DATA_WIDTH = 8;
    // CPOL=0, CPHA=0: SCLK idles low, data sampled on the rising edge.
    localparam int SPI_MODE   = 0;
    localparam int BIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        TRANSFER = 2'd2,
        DONE     = 2'd3
    } state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: counts CLK_DIV clk cycles per half-period while enabled,
// flags the boundary at the end of each low / high half-period and owns the
// registered SCLK level. park holds SCLK low at the final boundary so the
// frame can close without an extra rising edge.
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic park_i,
    output logic rise_strb_o,
    output logic fall_strb_o,
    output logic sclk_o
);

    logic [7:0] cnt_q, cnt_d;
    logic       sclk_q, sclk_d;
    logic       tick;

    assign tick        = (cnt_q == 8'(CLK_DIV - 1));
    // rise_strb marks the end of a low half-period (SCLK rises unless parked)
    assign rise_strb_o = en_i & tick & ~sclk_q;
    assign fall_strb_o = en_i & tick &  sclk_q;
    assign sclk_o      = sclk_q;

    // Half-period counter and SCLK toggle; disabled means counter cleared, SCLK low
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (tick) begin
            cnt_d = '0;
            if (sclk_q)       sclk_d = 1'b0;
            else if (!park_i) sclk_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Divider state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one 8-bit full-duplex frame per accepted start.
// SETUP holds CS low for one half-period before the first rising edge;
// TRANSFER runs 16 half-periods; DONE publishes the received byte.
// Every output is a flop loaded from next-state values.
module spi_master #(
    parameter int CLK_DIV    = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] masterDataToSend,
    output logic [DATA_WIDTH-1:0] masterDataReceived,
    output logic                  busy,
    output logic                  done,
    output logic                  SCLK,
    output logic                  CS,
    output logic                  MOSI,
    input  logic                  MISO
);

    import spi_pkg::*;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  tx_q, tx_d;
    logic [DATA_WIDTH-1:0]  rx_q, rx_d;
    logic [DATA_WIDTH-1:0]  rcv_q, rcv_d;
    logic [BIT_CNT_W-1:0]   bit_q, bit_d;
    logic                   cs_q, cs_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   mosi_q, mosi_d;
    logic                   gen_en, last_bit, rise_strb, fall_strb;

    assign gen_en   = (state_q == SETUP) || (state_q == TRANSFER);
    assign last_bit = (bit_q == BIT_CNT_W'(DATA_WIDTH));

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk         (clk),
        .reset       (reset),
        .en_i        (gen_en),
        .park_i      (last_bit),
        .rise_strb_o (rise_strb),
        .fall_strb_o (fall_strb),
        .sclk_o      (SCLK)
    );

    // Next-state, shift registers and registered-output next values
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rcv_d   = rcv_q;
        bit_d   = bit_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d    = masterDataToSend;
                    rx_d    = '0;
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // end of the leading low half-period is the first rising edge
                if (rise_strb) begin
                    rx_d    = {rx_q[DATA_WIDTH-2:0], MISO};
                    bit_d   = bit_q + 1'b1;
                    state_d = TRANSFER;
                end
            end
            TRANSFER: begin
                if (rise_strb) begin
                    if (last_bit) begin
                        rcv_d   = rx_q;
                        state_d = DONE;
                    end else begin
                        rx_d  = {rx_q[DATA_WIDTH-2:0], MISO};
                        bit_d = bit_q + 1'b1;
                    end
                end
                // the 8th fall leaves MOSI alone: nothing left to send
                if (fall_strb && !last_bit) begin
                    tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cs_d   = !((state_d == SETUP) || (state_d == TRANSFER));
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        mosi_d = ((state_d == SETUP) || (state_d == TRANSFER)) ? tx_d[DATA_WIDTH-1] : 1'b0;
    end

    // State, datapath and output registers; reset wins over start
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            rcv_q   <= '0;
            bit_q   <= '0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rcv_q   <= rcv_d;
            bit_q   <= bit_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mosi_q  <= mosi_d;
        end
    end

    assign masterDataReceived = rcv_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign CS                 = cs_q;
    assign MOSI               = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a behavioural mode-0 slave on a CLK_DIV=2 instance,
// and a MOSI->MISO loopback on a CLK_DIV=1 instance.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start2 = 1'b0, start1 = 1'b0;
    logic [7:0] data2 = 8'h00, data1 = 8'h00;
    logic [7:0] mdr2, mdr1;
    logic       busy2, done2, sclk2, cs2, mosi2;
    logic       busy1, done1, sclk1, cs1, mosi1, miso1;
    logic       miso2 = 1'b0;

    int total = 0, bad = 0;
    int cyc = 0, rises = 0, dones = 0;

    // behavioural slave state
    logic [7:0] slave_tx = 8'h00;
    logic [7:0] slave_rx = 8'h00;
    logic [7:0] sh = 8'h00;
    logic       cs_p = 1'b1, sclk_p = 1'b0;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] sl;
        logic [7:0] exp_mdr;
        logic [7:0] exp_srx;
        int         exp_lat;
    } vec_t;
    vec_t vecs[6];

    spi_master #(.CLK_DIV(2), .DATA_WIDTH(8)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .masterDataToSend(data2),
        .masterDataReceived(mdr2), .busy(busy2), .done(done2),
        .SCLK(sclk2), .CS(cs2), .MOSI(mosi2), .MISO(miso2)
    );

    spi_master #(.CLK_DIV(1), .DATA_WIDTH(8)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .masterDataToSend(data1),
        .masterDataReceived(mdr1), .busy(busy1), .done(done1),
        .SCLK(sclk1), .CS(cs1), .MOSI(mosi1), .MISO(miso1)
    );

    assign miso1 = mosi1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (done2) dones <= dones + 1;
    always @(posedge sclk2) rises <= rises + 1;

    // mode-0 slave: present MSB when selected, shift out on falls, sample on rises
    always @(cs2 or sclk2) begin
        if (cs_p && !cs2) begin
            sh    = slave_tx;
            miso2 = sh[7];
        end else if (!cs2 && sclk_p && !sclk2) begin
            sh    = {sh[6:0], 1'b0};
            miso2 = sh[7];
        end
        if (!cs2 && !sclk_p && sclk2) slave_rx = {slave_rx[6:0], mosi2};
        cs_p   = cs2;
        sclk_p = sclk2;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // called at a negedge in an idle cycle; returns one negedge after acceptance
    task automatic start_frame(input logic [7:0] t, input logic [7:0] s, output int c0);
        slave_tx = s;
        data2    = t;
        start2   = 1'b1;
        c0       = cyc;
        @(negedge clk);
        start2   = 1'b0;
    endtask

    // returns at the negedge of the cycle where done is high
    task automatic wait_done(input int c0, input bit scramble, output int lat, output bit seen);
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (done2) begin
                seen = 1'b1;
                lat  = cyc - c0;
            end else begin
                if (scramble) data2 = 8'($urandom);
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_rises(input int rc0, input int n);
        for (int i = 0; i < 400 && (rises - rc0) < n; i++) @(negedge clk);
    endtask

    int         c0, lat, rc0, dc0, gap, nbusy;
    bit         seen;
    logic [7:0] t, s, last_s;

    initial begin
        vecs[0] = '{8'b01010011, 8'b00001001, 8'b00001001, 8'b01010011, 35};
        vecs[1] = '{8'b00111100, 8'b10011000, 8'b10011000, 8'b00111100, 35};
        vecs[2] = '{8'b11010111, 8'b01101010, 8'b01101010, 8'b11010111, 35};
        vecs[3] = '{8'h00,       8'hFF,       8'hFF,       8'h00,       35};
        vecs[4] = '{8'hFF,       8'h00,       8'h00,       8'hFF,       35};
        vecs[5] = '{8'b10000001, 8'b01111110, 8'b01111110, 8'b10000001, 35};

        // reset, then ten idle cycles
        repeat (3) @(negedge clk);
        chk("reset_state", {cs2, sclk2, busy2, done2, mosi2, mdr2}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle2", {cs2, sclk2, busy2, done2, mdr2}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
            chk("idle1", {cs1, sclk1, busy1, done1, mdr1}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        end

        // table-driven frames
        for (int v = 0; v < 6; v++) begin
            rc0 = rises;
            start_frame(vecs[v].tx, vecs[v].sl, c0);
            chk("setup_outputs", {cs2, sclk2, busy2, mosi2}, {1'b0, 1'b0, 1'b1, vecs[v].tx[7]});
            wait_done(c0, 1'b0, lat, seen);
            chk("done_seen", 32'(seen), 1);
            chk("mdr", 32'(mdr2), 32'(vecs[v].exp_mdr));
            chk("slave_rx", 32'(slave_rx), 32'(vecs[v].exp_srx));
            chk("latency", 32'(lat), 32'(vecs[v].exp_lat));
            chk("sclk_rises", 32'(rises - rc0), 8);
            chk("done_cs_busy", {cs2, sclk2, busy2}, {1'b1, 1'b0, 1'b1});
            @(negedge clk);
            chk("after_done", {done2, busy2, cs2, sclk2}, {1'b0, 1'b0, 1'b1, 1'b0});
        end

        // back-to-back: start driven in the idle cycle right after done
        start_frame(8'b00111100, 8'b10011000, c0);
        wait_done(c0, 1'b0, lat, seen);
        chk("b2b1_mdr", 32'(mdr2), 32'(8'b10011000));
        @(negedge clk);
        gap = (cs2 && !done2) ? 1 : 0;
        start_frame(8'b11010111, 8'b01101010, c0);
        if (cs2) gap++;
        chk("b2b_cs_gap", 32'(gap), 1);
        wait_done(c0, 1'b0, lat, seen);
        chk("b2b2_mdr", 32'(mdr2), 32'(8'b01101010));
        chk("b2b2_srx", 32'(slave_rx), 32'(8'b11010111));
        chk("b2b2_lat", 32'(lat), 35);
        @(negedge clk);

        // start pulsed mid-frame must be ignored
        rc0 = rises;
        start_frame(8'b10111010, 8'b11010111, c0);
        wait_rises(rc0, 3);
        data2  = 8'hFF;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_done(c0, 1'b0, lat, seen);
        chk("ign_mdr", 32'(mdr2), 32'(8'b11010111));
        chk("ign_srx", 32'(slave_rx), 32'(8'b10111010));
        chk("ign_lat", 32'(lat), 35);
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy2 || !cs2) nbusy++;
        end
        chk("ign_no_second_frame", 32'(nbusy), 0);

        // reset after four rising edges aborts the frame
        rc0 = rises;
        dc0 = dones;
        start_frame(8'hC3, 8'h5A, c0);
        wait_rises(rc0, 4);
        chk("abort_reached_4", 32'(rises - rc0), 4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_outputs", {cs2, busy2, done2, sclk2, mdr2}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 32'(dones - dc0), 0);
        rc0 = rises;
        start_frame(8'b01010011, 8'b00001001, c0);
        wait_done(c0, 1'b0, lat, seen);
        chk("post_abort_mdr", 32'(mdr2), 32'(8'b00001001));
        chk("post_abort_srx", 32'(slave_rx), 32'(8'b01010011));
        chk("post_abort_lat", 32'(lat), 35);
        chk("post_abort_rises", 32'(rises - rc0), 8);

        // randomized frames; input data scrambled after acceptance
        last_s = 8'b00001001;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            t   = 8'($urandom);
            s   = 8'($urandom);
            rc0 = rises;
            start_frame(t, s, c0);
            chk("rnd_hold", 32'(mdr2), 32'(last_s));
            wait_done(c0, 1'b1, lat, seen);
            chk("rnd_mdr", 32'(mdr2), 32'(s));
            chk("rnd_srx", 32'(slave_rx), 32'(t));
            chk("rnd_lat", 32'(lat), 35);
            chk("rnd_rises", 32'(rises - rc0), 8);
            last_s = s;
        end
        @(negedge clk);

        // CLK_DIV=1 loopback
        data1  = 8'b10100101;
        start1 = 1'b1;
        c0     = cyc;
        @(negedge clk);
        start1 = 1'b0;
        data1  = 8'h3C;
        seen   = 1'b0;
        lat    = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done1) begin
                seen = 1'b1;
                lat  = cyc - c0;
            end else begin
                @(negedge clk);
            end
        end
        chk("lb_done_seen", 32'(seen), 1);
        chk("lb_mdr", 32'(mdr1), 32'(8'b10100101));
        chk("lb_lat", 32'(lat), 18);
        @(negedge clk);
        chk("lb_after_done", {done1, busy1, cs1}, {1'b0, 1'b0, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
